regwb_queue: RTL



---
 rtl/regwb_pkg.sv | 11 +
 rtl/regwb_fifo.sv | 55 +++++
 rtl/regwb_queue.sv | 89 ++++++++
 3 files changed

// File: rtl/regwb_pkg.sv
// Shared types and constants for the register write-back queue.
package regwb_pkg;
  localparam int REG_W      = 16;
  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 8;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dr;
    logic [REG_W-1:0]      data;
  } wb_entry_t;
endpackage

// File: rtl/regwb_fifo.sv
// Write-back FIFO: storage, wrapping pointers and a separate occupancy count.
// Entries are exposed oldest-first (index 0 = head) for the bypass search.
module regwb_fifo
  import regwb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  wb_entry_t                 wr_entry,
  output wb_entry_t                 head,
  output logic [$clog2(DEPTH):0]    count,
  output wb_entry_t [DEPTH-1:0]     entries,
  output logic [DEPTH-1:0]          valid
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  wb_entry_t     mem [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_entry;
  end

  assign head = mem[rd_ptr];

  always_comb begin
    entries = '0;
    valid   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      entries[k] = mem[rd_ptr + PW'(k)];
      valid[k]   = (count > (PW+1)'(k));
    end
  end
endmodule

// File: rtl/regwb_queue.sv
// Register-file write-back queue with registered drain stage.
// Optional read forwarding of pending writes is enabled by REGWB_BYPASS_EN.
module regwb_queue
  import regwb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [2:0]  wb_dr,
  input  logic [15:0] wb_data,
  input  logic        flush,
  output logic        regWE,
  output logic [2:0]  DR,
  output logic [15:0] Buss,
  output logic [3:0]  pending
`ifdef REGWB_BYPASS_EN
  ,
  input  logic [2:0]  SR1,
  input  logic [2:0]  SR2,
  input  logic [15:0] Ra_rf,
  input  logic [15:0] Rb_rf,
  output logic [15:0] Ra,
  output logic [15:0] Rb
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  push;
  logic                  pop;
  wb_entry_t             head;
  logic [CW-1:0]         count;
  wb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      valid;

  // Ready depends only on the registered count and flush, never on wb_valid.
  assign wb_ready = (count < CW'(DEPTH)) && !flush;
  assign push     = wb_valid && wb_ready;
  assign pop      = (count != '0) && !flush;

  regwb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .wr_entry ('{dr: wb_dr, data: wb_data}),
    .head     (head),
    .count    (count),
    .entries  (entries),
    .valid    (valid)
  );

  // Flush leaves an entry already on regWE alone; it simply loads nothing new.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regWE <= 1'b0;
      DR    <= '0;
      Buss  <= '0;
    end else begin
      regWE <= pop;
      if (pop) begin
        DR   <= head.dr;
        Buss <= head.data;
      end
    end
  end

  assign pending = 4'(count) + {3'b000, regWE};

`ifdef REGWB_BYPASS_EN
  // Oldest-to-youngest scan so the youngest matching FIFO entry wins.
  always_comb begin
    Ra = Ra_rf;
    Rb = Rb_rf;
    if (regWE && DR == SR1) Ra = Buss;
    if (regWE && DR == SR2) Rb = Buss;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid[k] && entries[k].dr == SR1) Ra = entries[k].data;
      if (valid[k] && entries[k].dr == SR2) Rb = entries[k].data;
    end
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{entries, valid};
`endif
endmodule
